// File: rtl/miner_job_ctrl.sv
// Job controller for the multi-lane miner: loads midstate/header words, arms and runs LANES
// SHA lanes on disjoint nonce slices, and queues golden nonces for the host. Optional: MINER_EARLY_STOP_EN.

module miner_lane_pend (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        found,
  input  logic [31:0] nonce,
  input  logic        grant,
  output logic        pend_valid,
  output logic [31:0] pend_nonce,
  output logic        drop
);
  logic        valid_q, valid_d;
  logic [31:0] nonce_q, nonce_d;

  always_comb begin
    valid_d = valid_q;
    nonce_d = nonce_q;
    drop    = 1'b0;
    if (clr) begin
      valid_d = 1'b0;
      nonce_d = '0;
    end else begin
      if (grant) valid_d = 1'b0;
      // A held result is never overwritten; the newcomer is counted as lost.
      if (found) begin
        if (valid_q) drop = 1'b1;
        else begin
          valid_d = 1'b1;
          nonce_d = nonce;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      nonce_q <= '0;
    end else begin
      valid_q <= valid_d;
      nonce_q <= nonce_d;
    end
  end

  assign pend_valid = valid_q;
  assign pend_nonce = nonce_q;
endmodule

module miner_job_ctrl #(
  parameter int LANES      = 4,
  parameter int MID_WORDS  = 8,
  parameter int HEAD_WORDS = 16,
  parameter int RES_DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_found,
  input  logic                    shift_in_enable,
  input  logic [31:0]             in_data,
  output logic [32*MID_WORDS-1:0] mid_data,
  output logic [32*HEAD_WORDS-1:0] head_data,
  output logic                    lane_load,
  output logic                    lane_solve,
  output logic [32*LANES-1:0]     lane_nonce_base,
  input  logic [LANES-1:0]        lane_found,
  input  logic [32*LANES-1:0]     lane_nonce,
  input  logic [LANES-1:0]        lane_exhausted,
  output logic                    sol_claim,
  output logic [31:0]             out_data,
  input  logic                    sol_response,
  output logic                    busy,
  output logic                    job_done,
  output logic [31:0]             solve_cycles,
  output logic [7:0]              drop_count
);
  localparam int LG  = $clog2(LANES);
  localparam int AW  = $clog2(RES_DEPTH);
  localparam int MAXW = (MID_WORDS > HEAD_WORDS) ? MID_WORDS : HEAD_WORDS;
  localparam int WW  = $clog2(MAXW + 1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(RES_DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD_MID, LOAD_HEAD, ARM, SOLVE, DRAIN} state_e;

  state_e                     state_q, state_d;
  logic [32*MID_WORDS-1:0]    mid_q, mid_d;
  logic [32*HEAD_WORDS-1:0]   head_q, head_d;
  logic [WW-1:0]              wcnt_q, wcnt_d;
  logic [LANES-1:0][31:0]     base_q, base_d;
  logic [RES_DEPTH-1:0][31:0] fifo_q, fifo_d;
  logic [AW-1:0]              rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]                cnt_q, cnt_d;
  logic [31:0]                solve_q, solve_d;
  logic [7:0]                 drop_q, drop_d;
  logic                       load_q, load_d, solve_en_q, solve_en_d;
  logic                       busy_q, busy_d, done_q, done_d;

  logic [LANES-1:0][31:0] lane_nonce_a, pend_nonce;
  logic [LANES-1:0]       pend_valid, grant, drop_l;
  logic                   pop, push, push_ok;
  logic [31:0]            push_nonce;
  logic [4:0]             ndrop;
  logic [8:0]             drop_sum;

  assign lane_nonce_a = lane_nonce;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    miner_lane_pend u_pend (
      .clk        (clk),
      .rst        (rst),
      .clr        (start_found),
      .found      (lane_found[i]),
      .nonce      (lane_nonce_a[i]),
      .grant      (grant[i]),
      .pend_valid (pend_valid[i]),
      .pend_nonce (pend_nonce[i]),
      .drop       (drop_l[i])
    );
  end

  assign pop     = sol_response && (cnt_q != '0);
  assign push_ok = (cnt_q != FULL_CNT) || pop;

  // Fixed priority: the loop runs high to low so the lowest pending lane wins.
  always_comb begin
    grant      = '0;
    push_nonce = '0;
    for (int i = LANES-1; i >= 0; i--) begin
      if (pend_valid[i] && push_ok && !start_found) begin
        grant      = '0;
        grant[i]   = 1'b1;
        push_nonce = pend_nonce[i];
      end
    end
  end
  assign push = |grant;

  always_comb begin
    state_d = state_q;
    mid_d   = mid_q;
    head_d  = head_q;
    wcnt_d  = wcnt_q;
    base_d  = base_q;
    fifo_d  = fifo_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    solve_d = solve_q;
    drop_d  = drop_q;
    ndrop   = '0;

    for (int i = 0; i < LANES; i++) ndrop = ndrop + 5'(drop_l[i]);
    drop_sum = {1'b0, drop_q} + {4'b0, ndrop};
    drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];

    if (push) begin
      fifo_d[wr_q] = push_nonce;
      wr_d = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    if (state_q == SOLVE && solve_q != '1) solve_d = solve_q + 32'd1;

    case (state_q)
      LOAD_MID: if (shift_in_enable) begin
        mid_d = mid_q << 32;
        mid_d[31:0] = in_data;
        if (wcnt_q == WW'(MID_WORDS-1)) begin
          wcnt_d  = '0;
          state_d = LOAD_HEAD;
        end else wcnt_d = wcnt_q + 1'b1;
      end
      LOAD_HEAD: if (shift_in_enable) begin
        head_d = head_q << 32;
        head_d[31:0] = in_data;
        if (wcnt_q == WW'(HEAD_WORDS-1)) begin
          wcnt_d  = '0;
          state_d = ARM;
        end else wcnt_d = wcnt_q + 1'b1;
      end
      ARM: state_d = SOLVE;
      SOLVE: begin
        if (&lane_exhausted) state_d = DRAIN;
`ifdef MINER_EARLY_STOP_EN
        if (push) state_d = DRAIN;
`endif
      end
      // A strobe arriving this cycle still has to be queued before completion.
      DRAIN: if (!(|pend_valid) && !(|lane_found)) state_d = IDLE;
      default: ;
    endcase

    if (state_d == ARM && state_q != ARM)
      for (int i = 0; i < LANES; i++)
        base_d[i] = (LG == 0) ? 32'd0 : (32'(i) << (32 - LG));

    if (start_found) begin
      state_d = LOAD_MID;
      mid_d   = '0;
      head_d  = '0;
      wcnt_d  = '0;
      fifo_d  = '0;
      rd_d    = '0;
      wr_d    = '0;
      cnt_d   = '0;
      solve_d = '0;
      drop_d  = '0;
    end

    load_d     = (state_d == ARM);
    solve_en_d = (state_d == SOLVE);
    busy_d     = (state_d != IDLE);
    done_d     = (state_q == DRAIN) && (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mid_q      <= '0;
      head_q     <= '0;
      wcnt_q     <= '0;
      base_q     <= '0;
      fifo_q     <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
      solve_q    <= '0;
      drop_q     <= '0;
      load_q     <= 1'b0;
      solve_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mid_q      <= mid_d;
      head_q     <= head_d;
      wcnt_q     <= wcnt_d;
      base_q     <= base_d;
      fifo_q     <= fifo_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      solve_q    <= solve_d;
      drop_q     <= drop_d;
      load_q     <= load_d;
      solve_en_q <= solve_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign mid_data        = mid_q;
  assign head_data       = head_q;
  assign lane_load       = load_q;
  assign lane_solve      = solve_en_q;
  assign lane_nonce_base = base_q;
  assign sol_claim       = (cnt_q != '0);
  assign out_data        = sol_claim ? fifo_q[rd_q] : 32'd0;
  assign busy            = busy_q;
  assign job_done        = done_q;
  assign solve_cycles    = solve_q;
  assign drop_count      = drop_q;
endmodule

// File: doc/miner_job_ctrl.md
# miner_job_ctrl

Parametrised job controller for the multi-lane Bitcoin miner.
- Loads one job's midstate and header words over the 32-bit serial word bus.
- Broadcasts the job to LANES external SHA lanes, giving each lane a disjoint nonce slice.
- Collects golden nonces from the lanes into a result FIFO that the host drains with a claim/response handshake.
- Sits between the host word interface and the lane array, replacing the single-lane core.

## Interface
Parameters:
- LANES, 4, number of hash lanes; power of two, 1..16
- MID_WORDS, 8, midstate words per job
- HEAD_WORDS, 16, header words per job
- RES_DEPTH, 4, result FIFO entries; power of two, ≥2

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start_found  in  1  begin new job; synchronous abort of everything
- shift_in_enable  in  1  in_data valid this cycle
- in_data  in  32  job word
- mid_data  out  32*MID_WORDS  midstate to all lanes
- head_data  out  32*HEAD_WORDS  header to all lanes
- lane_load  out  1  one-cycle load strobe to all lanes
- lane_solve  out  1  lanes hash while high
- lane_nonce_base  out  32*LANES  start nonce; lane i in bits [32i+31:32i]
- lane_found  in  LANES  one-cycle golden-nonce strobe per lane
- lane_nonce  in  32*LANES  nonce qualified by lane_found
- lane_exhausted  in  LANES  level; lane finished its slice
- sol_claim  out  1  result FIFO non-empty
- out_data  out  32  FIFO head nonce
- sol_response  in  1  pop FIFO head
- busy  out  1  state ≠ IDLE
- job_done  out  1  one-cycle pulse at job completion
- solve_cycles  out  32  cycles spent in SOLVE, saturating
- drop_count  out  8  results lost to pending overrun, saturating

## Operation
- States: IDLE, LOAD_MID, LOAD_HEAD, ARM, SOLVE, DRAIN.
- start_found (any state) clears the following, and the next state is LOAD_MID:
  - shift registers, word counter, pending regs, FIFO, solve_cycles, drop_count.
  - in_data on that cycle is not captured.
- LOAD_MID
  - Each shift_in_enable shifts mid_data left by 32 bits and inserts in_data at [31:0]; the first word ends up most significant.
  - After MID_WORDS words, go to LOAD_HEAD.
- LOAD_HEAD
  - Same shifting into head_data.
  - After HEAD_WORDS words, go to ARM.
- shift_in_enable is ignored outside the two LOAD states.
- ARM: single cycle.
  - lane_load = 1.
  - lane_nonce_base[i] = i << (32 − log2 LANES); LANES = 1 gives 0.
  - Next state is SOLVE.
- SOLVE: lane_solve = 1; solve_cycles increments each cycle.
  - Exit to DRAIN when all lane_exhausted bits are high.
- Result path:
  - Each lane has one pending register (valid + nonce), set by lane_found.
  - If lane_found arrives while that lane's pending register is valid, the new result is dropped and drop_count increments.
  - Each cycle the fixed-priority arbiter (lowest lane index first) moves one pending entry into the FIFO if the FIFO is not full.
  - If the FIFO is full, pending entries wait.
- Host handshake:
  - sol_response while sol_claim pops the head at the clock edge.
  - sol_response while the FIFO is empty is ignored.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full.
- DRAIN
  - lane_solve = 0.
  - When no pending register is valid: pulse job_done, go to IDLE.
- FIFO contents survive into IDLE until popped or until start_found.
- Counters saturate at all-ones; no wrap.

## Timing
- Reset values: every output 0; state IDLE.
- Word capture happens at the edge where shift_in_enable = 1. After that edge, mid_data/head_data reflect the word.
- lane_load is high in the cycle after the edge capturing the last header word.
- lane_solve rises one cycle after lane_load.
- lane_found sampled at edge N:
  - the pending register is valid after N;
  - the FIFO entry is present and sol_claim is high after N+1, provided the FIFO had room and no lower lane was pending.
- The pop takes effect at the edge with sol_response = 1. out_data shows the next entry after that edge.
- lane_found and lane_exhausted from the same lane in the same cycle: the result is still captured and reported before job_done.
- An asserted rst mid-job behaves as a full clear, identical to the reset values.

## Configuration
- MINER_EARLY_STOP_EN defined:
  - SOLVE also exits to DRAIN on the first FIFO push of the job.
  - lane_solve drops one cycle after that push.
  - Later lane_found strobes are still captured.
- Not defined: SOLVE runs until every lane is exhausted.

## Test plan
- Reset, then idle: all outputs 0, busy = 0. Send 3 shift_in_enable words in IDLE → mid_data stays 0.
- start_found, then words 0x1..0x8 and 0x9..0x18 → mid_data = {0x1,…,0x8}, head_data = {0x9,…,0x18}. lane_load pulses one cycle later. LANES = 4 bases are 0x0, 0x40000000, 0x80000000, 0xC0000000.
- Lanes 0 and 3 raise lane_found in the same cycle with nonces 0x11 and 0xC0000022 → sol_claim 2 edges later with out_data = 0x11. After one pop, out_data = 0xC0000022. After a second pop, sol_claim = 0.
- Keep sol_response low with RES_DEPTH = 4 and fire 6 results from lane 1 two cycles apart → FIFO holds 4, lane 1 pending holds 1, drop_count = 1.
- Assert start_found mid-SOLVE with 2 FIFO entries → sol_claim = 0, state LOAD_MID, solve_cycles = 0.
- Raise all lane_exhausted after 100 SOLVE cycles → solve_cycles = 100, job_done pulses once, busy = 0. With MINER_EARLY_STOP_EN, the first found ends SOLVE before exhaustion.
